// File: rtl/image_streamer_pkg.sv
// image_streamer_pkg
//   Shared fixed-point definitions for the image_streamer / regnet pair.
//   DATA_WIDTH     : total fixed-point width
//   FRACTION_WIDTH : fractional bits (half of DATA_WIDTH)
//   fixed_point    : {integral, fraction} packed struct
//   pixel_to_fixed : raw 8-bit pixel -> pixel/256 as fixed_point
package image_streamer_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int FRACTION_WIDTH = DATA_WIDTH / 2;

  typedef struct packed {
    logic [DATA_WIDTH-FRACTION_WIDTH-1:0] integral;
    logic [FRACTION_WIDTH-1:0]            fraction;
  } fixed_point;

  // Unsigned, never saturates: the byte lands in the top bits of the fraction.
  function automatic fixed_point pixel_to_fixed(input logic [7:0] pixel);
    fixed_point f;
    f.integral = '0;
    f.fraction = {pixel, {(FRACTION_WIDTH-8){1'b0}}};
    return f;
  endfunction

endpackage

// File: rtl/image_streamer_if.sv
// image_streamer_if
//   Bundles the pixel-byte handshake and the network-facing frame bus.
//   byte_valid/byte_data/byte_ready : upstream byte handshake
//   image_ready/pixels              : frame burst towards regnet
//   label_ready                     : classification done from regnet
//   busy                            : streamer is in STREAM or WAIT
//   Modports: slave = the streamer, master = the surrounding environment.
interface image_streamer_if
  import image_streamer_pkg::*;
#(
  parameter int INPUT_SIZE  = 1,
  parameter int PIXEL_WIDTH = 8
) ();

  logic                   byte_valid;
  logic [PIXEL_WIDTH-1:0] byte_data;
  logic                   byte_ready;
  logic                   image_ready;
  fixed_point             pixels [INPUT_SIZE];
  logic                   label_ready;
  logic                   busy;

  modport slave (
    input  byte_valid, byte_data, label_ready,
    output byte_ready, image_ready, pixels, busy
  );

  modport master (
    output byte_valid, byte_data, label_ready,
    input  byte_ready, image_ready, pixels, busy
  );

endinterface

// File: rtl/image_streamer.sv
// image_streamer
//   Buffers one grayscale frame of NUM_PIXELS bytes, then bursts it to regnet
//   INPUT_SIZE fixed-point pixels per cycle, then waits for label_ready.
//   Ports:
//     clock   : single clock
//     reset_n : synchronous active-low reset
//     bus     : image_streamer_if.slave (byte handshake, frame bus, label, busy)
//
//   state  | meaning
//   LOAD   | accepting bytes into the frame buffer
//   STREAM | presenting one chunk per cycle, image_ready high
//   WAIT   | burst done, waiting for label_ready
module image_streamer
  import image_streamer_pkg::*;
#(
  parameter int NUM_PIXELS  = 784,
  parameter int INPUT_SIZE  = 1,
  parameter int PIXEL_WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  image_streamer_if.slave   bus
);

  localparam int NUM_CHUNKS = (NUM_PIXELS + INPUT_SIZE - 1) / INPUT_SIZE;
  localparam int LW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {S_LOAD, S_STREAM, S_WAIT} state_t;

  state_t                 r_state, w_state_nxt;
  logic [PIXEL_WIDTH-1:0] r_buffer [NUM_PIXELS];
  logic [LW-1:0]          r_load_count, w_load_nxt;
  logic [CW-1:0]          r_chunk_count, w_chunk_nxt;
  logic                   w_wr;
  logic [31:0]            w_idx;
  logic [PIXEL_WIDTH-1:0] w_byte;
  fixed_point             w_pixels_nxt [INPUT_SIZE];

  logic                   r_byte_ready;
  logic                   r_image_ready;
  logic                   r_busy;
  fixed_point             r_pixels [INPUT_SIZE];

  always_comb begin
    w_wr        = (r_state == S_LOAD) && bus.byte_valid;
    w_state_nxt = r_state;
    w_load_nxt  = r_load_count;
    w_chunk_nxt = r_chunk_count;
    case (r_state)
      S_LOAD: begin
        if (w_wr) begin
          if (r_load_count == LW'(NUM_PIXELS - 1)) begin
            w_state_nxt = S_STREAM;
            w_load_nxt  = '0;
            w_chunk_nxt = '0;
          end else begin
            w_load_nxt = r_load_count + 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (r_chunk_count == CW'(NUM_CHUNKS - 1)) begin
          w_state_nxt = S_WAIT;
          w_chunk_nxt = '0;
        end else begin
          w_chunk_nxt = r_chunk_count + 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.label_ready) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Registered pixel lanes are computed from the next chunk index. The byte
  // being written on the same edge is forwarded so a chunk containing the
  // final pixel is correct on the first STREAM cycle.
  always_comb begin
    w_idx  = '0;
    w_byte = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      w_pixels_nxt[i] = '0;
      if (w_state_nxt == S_STREAM) begin
        w_idx = 32'(w_chunk_nxt) * 32'(INPUT_SIZE) + 32'(i);
        if (w_idx < 32'(NUM_PIXELS)) begin
          if (w_wr && (32'(r_load_count) == w_idx)) w_byte = bus.byte_data;
          else                                      w_byte = r_buffer[LW'(w_idx)];
          w_pixels_nxt[i] = pixel_to_fixed(8'(w_byte));
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && w_wr) r_buffer[r_load_count] <= bus.byte_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= S_LOAD;
      r_load_count  <= '0;
      r_chunk_count <= '0;
      r_byte_ready  <= 1'b1;
      r_image_ready <= 1'b0;
      r_busy        <= 1'b0;
      for (int i = 0; i < INPUT_SIZE; i++) r_pixels[i] <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_load_count  <= w_load_nxt;
      r_chunk_count <= w_chunk_nxt;
      r_byte_ready  <= (w_state_nxt == S_LOAD);
      r_image_ready <= (w_state_nxt == S_STREAM);
      r_busy        <= (w_state_nxt != S_LOAD);
      r_pixels      <= w_pixels_nxt;
    end
  end

  assign bus.byte_ready  = r_byte_ready;
  assign bus.image_ready = r_image_ready;
  assign bus.busy        = r_busy;
  assign bus.pixels      = r_pixels;

endmodule

// File: tb/tb_image_streamer.sv
// tb_image_streamer
//   Directed bench for image_streamer with NUM_PIXELS=10: one instance with
//   INPUT_SIZE=1 (dut1) and one with INPUT_SIZE=4 (dut4).
module tb_image_streamer;
  import image_streamer_pkg::*;

  logic clock = 1'b0;
  logic rst_n1, rst_n4;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  image_streamer_if #(.INPUT_SIZE(1), .PIXEL_WIDTH(8)) if1 ();
  image_streamer_if #(.INPUT_SIZE(4), .PIXEL_WIDTH(8)) if4 ();

  image_streamer #(.NUM_PIXELS(10), .INPUT_SIZE(1), .PIXEL_WIDTH(8)) dut1 (
    .clock(clock), .reset_n(rst_n1), .bus(if1.slave));
  image_streamer #(.NUM_PIXELS(10), .INPUT_SIZE(4), .PIXEL_WIDTH(8)) dut4 (
    .clock(clock), .reset_n(rst_n4), .bus(if4.slave));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send1(input int base);
    for (int k = 0; k < 10; k++) begin
      if1.byte_valid = 1'b1;
      if1.byte_data  = 8'(base + k);
      tick();
    end
    if1.byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n1 = 1'b0;
    rst_n4 = 1'b0;
    tick();
    tick();
    checks++;
    if (if1.byte_ready !== 1'b1 || if1.image_ready !== 1'b0 || if1.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut1_ctrl got br=%b ir=%b busy=%b exp br=1 ir=0 busy=0",
               if1.byte_ready, if1.image_ready, if1.busy);
    end
    checks++;
    if (if1.pixels[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_dut1_pixels got %h exp 0", if1.pixels[0]);
    end
    checks++;
    if (if4.byte_ready !== 1'b1 || if4.image_ready !== 1'b0 || if4.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_dut4_ctrl got br=%b ir=%b busy=%b exp br=1 ir=0 busy=0",
               if4.byte_ready, if4.image_ready, if4.busy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (if4.pixels[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_dut4_lane%0d got %h exp 0", i, if4.pixels[i]);
      end
    end
    rst_n1 = 1'b1;
    rst_n4 = 1'b1;
  endtask

  task automatic test_basic_frame();
    logic [15:0] exp;
    for (int k = 0; k < 10; k++) begin
      if1.byte_valid = 1'b1;
      if1.byte_data  = 8'(k);
      checks++;
      if (if1.byte_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_load_ready byte %0d got %b exp 1", k, if1.byte_ready);
      end
      tick();
    end
    if1.byte_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp = 16'(k) << 8;
      checks++;
      if (if1.image_ready !== 1'b1 || if1.byte_ready !== 1'b0 || if1.busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_stream_ctrl cycle %0d got ir=%b br=%b busy=%b exp 1 0 1",
                 k, if1.image_ready, if1.byte_ready, if1.busy);
      end
      checks++;
      if (if1.pixels[0].fraction !== exp || if1.pixels[0].integral !== 16'h0) begin
        errors++;
        $display("FAIL basic_stream_pixel cycle %0d got %h exp %h", k, if1.pixels[0], {16'h0, exp});
      end
      tick();
    end
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (if1.image_ready !== 1'b0 || if1.busy !== 1'b1 || if1.byte_ready !== 1'b0 ||
          if1.pixels[0] !== 32'h0) begin
        errors++;
        $display("FAIL basic_wait cycle %0d got ir=%b busy=%b br=%b px=%h exp 0 1 0 0",
                 w, if1.image_ready, if1.busy, if1.byte_ready, if1.pixels[0]);
      end
      tick();
    end
  endtask

  task automatic test_label_handshake();
    logic [15:0] exp;
    // label in WAIT together with an offered byte that must not be taken
    if1.label_ready = 1'b1;
    if1.byte_valid  = 1'b1;
    if1.byte_data   = 8'd99;
    tick();
    if1.label_ready = 1'b0;
    if1.byte_valid  = 1'b0;
    checks++;
    if (if1.byte_ready !== 1'b1 || if1.busy !== 1'b0) begin
      errors++;
      $display("FAIL label_wait_exit got br=%b busy=%b exp br=1 busy=0", if1.byte_ready, if1.busy);
    end
    send1(20);
    for (int k = 0; k < 10; k++) begin
      exp = 16'(20 + k) << 8;
      checks++;
      if (if1.image_ready !== 1'b1 || if1.pixels[0].fraction !== exp) begin
        errors++;
        $display("FAIL label_frame2 cycle %0d got ir=%b px=%h exp ir=1 frac=%h",
                 k, if1.image_ready, if1.pixels[0], exp);
      end
      if1.label_ready = (k == 2);
      if1.byte_valid  = 1'b1;
      if1.byte_data   = 8'hEE;
      tick();
    end
    if1.label_ready = 1'b0;
    if1.byte_valid  = 1'b0;
    checks++;
    if (if1.image_ready !== 1'b0 || if1.busy !== 1'b1 || if1.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL label_ignored_in_stream got ir=%b busy=%b br=%b exp 0 1 0",
               if1.image_ready, if1.busy, if1.byte_ready);
    end
    if1.label_ready = 1'b1;
    tick();
    if1.label_ready = 1'b0;
    checks++;
    if (if1.byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL label_second_exit got br=%b exp 1", if1.byte_ready);
    end
  endtask

  task automatic test_gappy();
    logic [7:0]  vals [10];
    logic [15:0] exp;
    vals = '{8'd255, 8'd7, 8'd128, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd200};
    for (int k = 0; k < 10; k++) begin
      if1.byte_valid = 1'b1;
      if1.byte_data  = vals[k];
      tick();
      if1.byte_valid = 1'b0;
      if1.byte_data  = 8'hAA;
      if (k != 9) begin
        checks++;
        if (if1.byte_ready !== 1'b1 || if1.image_ready !== 1'b0) begin
          errors++;
          $display("FAIL gappy_still_loading after byte %0d got br=%b ir=%b exp 1 0",
                   k, if1.byte_ready, if1.image_ready);
        end
        tick();
      end
    end
    for (int k = 0; k < 10; k++) begin
      exp = {vals[k], 8'h00};
      checks++;
      if (if1.image_ready !== 1'b1 || if1.pixels[0].fraction !== exp ||
          if1.pixels[0].integral !== 16'h0) begin
        errors++;
        $display("FAIL gappy_stream cycle %0d got ir=%b px=%h exp ir=1 px=%h",
                 k, if1.image_ready, if1.pixels[0], {16'h0, exp});
      end
      tick();
    end
    checks++;
    if (if1.image_ready !== 1'b0 || if1.busy !== 1'b1) begin
      errors++;
      $display("FAIL gappy_wait got ir=%b busy=%b exp 0 1", if1.image_ready, if1.busy);
    end
    if1.label_ready = 1'b1;
    tick();
    if1.label_ready = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    logic [15:0] exp;
    send1(30);
    for (int k = 0; k < 4; k++) begin
      exp = 16'(30 + k) << 8;
      checks++;
      if (if1.image_ready !== 1'b1 || if1.pixels[0].fraction !== exp) begin
        errors++;
        $display("FAIL midrst_pre chunk %0d got ir=%b px=%h exp frac=%h",
                 k, if1.image_ready, if1.pixels[0], exp);
      end
      if (k != 3) tick();
    end
    rst_n1 = 1'b0;
    tick();
    rst_n1 = 1'b1;
    checks++;
    if (if1.image_ready !== 1'b0 || if1.byte_ready !== 1'b1 || if1.busy !== 1'b0 ||
        if1.pixels[0] !== 32'h0) begin
      errors++;
      $display("FAIL midrst_abort got ir=%b br=%b busy=%b px=%h exp 0 1 0 0",
               if1.image_ready, if1.byte_ready, if1.busy, if1.pixels[0]);
    end
    send1(40);
    for (int k = 0; k < 10; k++) begin
      exp = 16'(40 + k) << 8;
      checks++;
      if (if1.image_ready !== 1'b1 || if1.pixels[0].fraction !== exp) begin
        errors++;
        $display("FAIL midrst_fresh chunk %0d got ir=%b px=%h exp frac=%h",
                 k, if1.image_ready, if1.pixels[0], exp);
      end
      tick();
    end
    checks++;
    if (if1.image_ready !== 1'b0 || if1.busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_wait got ir=%b busy=%b exp 0 1", if1.image_ready, if1.busy);
    end
  endtask

  task automatic test_partial_chunk();
    int idx;
    logic [15:0] exp;
    for (int k = 0; k < 10; k++) begin
      if4.byte_valid = 1'b1;
      if4.byte_data  = 8'(10 + k);
      tick();
    end
    if4.byte_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (if4.image_ready !== 1'b1 || if4.byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL partial_ctrl chunk %0d got ir=%b br=%b exp 1 0",
                 c, if4.image_ready, if4.byte_ready);
      end
      for (int i = 0; i < 4; i++) begin
        idx = c * 4 + i;
        exp = (idx < 10) ? (16'(10 + idx) << 8) : 16'h0;
        checks++;
        if (if4.pixels[i].fraction !== exp || if4.pixels[i].integral !== 16'h0) begin
          errors++;
          $display("FAIL partial_lane chunk %0d lane %0d got %h exp %h",
                   c, i, if4.pixels[i], {16'h0, exp});
        end
      end
      tick();
    end
    checks++;
    if (if4.image_ready !== 1'b0 || if4.busy !== 1'b1) begin
      errors++;
      $display("FAIL partial_wait got ir=%b busy=%b exp 0 1", if4.image_ready, if4.busy);
    end
  endtask

  initial begin
    rst_n1 = 1'b0;
    rst_n4 = 1'b0;
    if1.byte_valid  = 1'b0;
    if1.byte_data   = 8'h0;
    if1.label_ready = 1'b0;
    if4.byte_valid  = 1'b0;
    if4.byte_data   = 8'h0;
    if4.label_ready = 1'b0;
    #2;
    test_reset();
    test_basic_frame();
    test_label_handshake();
    test_gappy();
    test_reset_mid_stream();
    test_partial_chunk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
